// File: rtl/counter_pkg.sv
// Shared types and helpers for the nested loop-index counter.
package counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cnt_state_e;

    // Low bit of level idx inside a packed LVL*DW bus.
    function automatic int unsigned lvl_lo(input int unsigned idx, input int unsigned dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/counter_level.sv
// One DW-bit level of the nested counter: steps on cin, wraps/reloads against max.
module counter_level #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cin,
    input  logic          clr,
    input  logic          load,
    input  logic          down,
    input  logic [DW-1:0] max,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] cnt,
    output logic          flag
);

    logic [DW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = load_val;
        end else if (cin) begin
            if (down) begin
                cnt_nxt = (cnt == '0) ? max : cnt - DW'(1);
            end else begin
                cnt_nxt = (cnt < max) ? cnt + DW'(1) : '0;
            end
        end
    end

    // ">=" lets a level left above a lowered max still carry as it wraps.
    assign flag = down ? (cnt == '0) : (cnt >= max);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/counter_nest.sv
// Nested multi-level counter with wrap and one-shot sweep modes.
// Optional down-counting enabled by defining COUNTER_NEST_DOWN_EN.
module counter_nest
    import counter_pkg::*;
#(
    parameter int DW  = 8,
    parameter int LVL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             oneshot,
    input  logic             start,
`ifdef COUNTER_NEST_DOWN_EN
    input  logic             down,
`endif
    input  logic [LVL*DW-1:0] max,
    output logic [LVL*DW-1:0] cnt,
    output logic [LVL-1:0]    co,
    output logic              busy,
    output logic              done
);

    cnt_state_e     state, state_nxt;
    logic           done_nxt;
    logic           step;
    logic           load;
    logic           down_i;
    logic [LVL-1:0] flag;
    logic [LVL-1:0] cin;

`ifdef COUNTER_NEST_DOWN_EN
    assign down_i = down;
`else
    assign down_i = 1'b0;
`endif

    assign step = oneshot ? (en & (state == ST_RUN)) : en;
    assign load = oneshot & start;

    // Carry chain: level i advances only when every inner level sits at its turn point.
    always_comb begin
        logic carry;
        carry = step;
        co    = '0;
        cin   = '0;
        for (int i = 0; i < LVL; i++) begin
            cin[i] = carry;
            carry  = carry & flag[i];
            co[i]  = carry;
        end
    end

    for (genvar i = 0; i < LVL; i++) begin : g_lvl
        counter_level #(.DW(DW)) u_level (
            .clk      (clk),
            .rst      (rst),
            .cin      (cin[i]),
            .clr      (clr),
            .load     (load),
            .down     (down_i),
            .max      (max[lvl_lo(i, DW) +: DW]),
            .load_val (down_i ? max[lvl_lo(i, DW) +: DW] : '0),
            .cnt      (cnt[lvl_lo(i, DW) +: DW]),
            .flag     (flag[i])
        );
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (!oneshot) begin
            state_nxt = ST_IDLE;
        end else if (!clr) begin
            if (start) begin
                state_nxt = ST_RUN;
            end else if ((state == ST_RUN) && co[LVL-1]) begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_counter_nest.sv
// Scoreboard bench for counter_nest: per-cycle expectations from a level-array model.
module tb_counter_nest;

  localparam int DW  = 4;
  localparam int LVL = 3;
  localparam int EW  = LVL*DW + LVL + 2;

  logic              clk = 1'b0;
  logic              rst, en, clr, oneshot, start, down;
  logic [LVL*DW-1:0] max, cnt;
  logic [LVL-1:0]    co;
  logic              busy, done;

  always #5 clk = ~clk;

  counter_nest #(.DW(DW), .LVL(LVL)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .oneshot (oneshot),
    .start   (start),
`ifdef COUNTER_NEST_DOWN_EN
    .down    (down),
`endif
    .max     (max),
    .cnt     (cnt),
    .co      (co),
    .busy    (busy),
    .done    (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  int m_cnt[LVL];
  bit m_run, m_done;

  int obs_done = 0;
  int obs_busy = 0;
  int obs_co2  = 0;

  function automatic int mx(input int i);
    return int'(max[i*DW +: DW]);
  endfunction

  function automatic logic [LVL-1:0] model_co(input bit step);
    logic [LVL-1:0] r;
    bit all;
    all = step;
    for (int i = 0; i < LVL; i++) begin
      all  = all && (down ? (m_cnt[i] == 0) : (m_cnt[i] >= mx(i)));
      r[i] = all;
    end
    return r;
  endfunction

  function automatic logic [EW-1:0] model_out(input logic [LVL-1:0] cov);
    logic [LVL*DW-1:0] cv;
    for (int i = 0; i < LVL; i++) cv[i*DW +: DW] = DW'(m_cnt[i]);
    return {cv, cov, m_run, m_done};
  endfunction

  // Drive one cycle, queue the expected outputs, then advance the model at the edge.
  task automatic cycle(input bit r, input bit e, input bit c, input bit s);
    bit step, nd;
    logic [LVL-1:0] cov;
    rst = r; en = e; clr = c; start = s;
    step = e && (!oneshot || m_run);
    cov  = model_co(step);
    exp_q.push_back(model_out(cov));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < LVL; i++) m_cnt[i] = 0;
      m_run  = 0;
      m_done = 0;
    end else begin
      nd = 0;
      if (c) begin
        for (int i = 0; i < LVL; i++) m_cnt[i] = 0;
      end else if (oneshot && s) begin
        for (int i = 0; i < LVL; i++) m_cnt[i] = down ? mx(i) : 0;
      end else if (step) begin
        for (int i = 0; i < LVL; i++) begin
          if (i == 0 || cov[i-1]) begin
            if (down) m_cnt[i] = (m_cnt[i] == 0) ? mx(i) : m_cnt[i] - 1;
            else      m_cnt[i] = (m_cnt[i] < mx(i)) ? m_cnt[i] + 1 : 0;
          end
        end
      end
      if (!oneshot) m_run = 0;
      else if (!c) begin
        if (s) m_run = 1;
        else if (m_run && cov[LVL-1]) begin
          m_run = 0;
          nd    = 1;
        end
      end
      m_done = nd;
    end
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    logic [EW-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {cnt, co, busy, done};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL out_vec @%0t: actual cnt=%h co=%b busy=%b done=%b required cnt=%h co=%b busy=%b done=%b",
                 $time, a[EW-1 -: LVL*DW], a[LVL+1 -: LVL], a[1], a[0],
                 e[EW-1 -: LVL*DW], e[LVL+1 -: LVL], e[1], e[0]);
      end
      if (done === 1'b1)  obs_done++;
      if (busy === 1'b1)  obs_busy++;
      if (co[LVL-1] === 1'b1) obs_co2++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b_done, b_busy, b_co;
    rst = 1; en = 0; clr = 0; oneshot = 0; start = 0; down = 0;
    max = {4'd2, 4'd1, 4'd3};
    for (int i = 0; i < LVL; i++) m_cnt[i] = 0;
    m_run = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check_val("reset_cnt", int'(cnt), 0);
    check_val("reset_busy_done", int'({busy, done}), 0);

    // Wrap mode: 30 enabled cycles, one co[2] and no done.
    b_done = obs_done; b_co = obs_co2;
    repeat (30) cycle(0, 1, 0, 0);
    check_val("wrap_done_count", obs_done - b_done, 0);
    check_val("wrap_co2_count", obs_co2 - b_co, 1);
    check_val("wrap_cnt_after30", int'(cnt), int'({4'd0, 4'd1, 4'd2}));

    // One-shot full sweep, then en without start holds.
    oneshot = 1;
    cycle(1, 0, 0, 0);
    b_done = obs_done; b_busy = obs_busy;
    cycle(0, 0, 0, 1);
    repeat (26) cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 1, 0, 0);
    check_val("sweep_busy_cycles", obs_busy - b_busy, 24);
    check_val("sweep_done_count", obs_done - b_done, 1);
    check_val("sweep_end_cnt", int'(cnt), 0);

    // Sweep with en toggling: 24 steps over 48 clocks.
    b_done = obs_done; b_busy = obs_busy;
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 50; k++) cycle(0, (k % 2) == 0, 0, 0);
    check_val("toggle_busy_cycles", obs_busy - b_busy, 47);
    check_val("toggle_done_count", obs_done - b_done, 1);

    // Mid-sweep restart, clear, reset.
    b_done = obs_done;
    cycle(0, 0, 0, 1);
    repeat (10) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    repeat (5) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    check_val("clr_keeps_busy", int'(busy), 1);
    check_val("clr_cnt", int'(cnt), 0);
    repeat (7) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check_val("rst_mid_sweep", int'({cnt, busy, done}), 0);
    check_val("mid_done_count", obs_done - b_done, 0);

    // Lowering max0 below cnt0 wraps it and carries.
    oneshot = 0;
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);
    max[3:0] = 4'd1;
    cycle(0, 1, 0, 0);
    check_val("max_lower_cnt0", int'(cnt[3:0]), 0);
    check_val("max_lower_cnt1", int'(cnt[7:4]), 1);

    // All max = 0: sweep ends on first enabled step.
    max = '0;
    oneshot = 1;
    b_done = obs_done; b_busy = obs_busy;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check_val("allzero_busy", obs_busy - b_busy, 2);
    check_val("allzero_done", obs_done - b_done, 1);

    // oneshot dropped mid-sweep: no done.
    max = {4'd2, 4'd1, 4'd3};
    b_done = obs_done;
    cycle(0, 0, 0, 1);
    repeat (5) cycle(0, 1, 0, 0);
    oneshot = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_val("drop_oneshot_busy", int'(busy), 0);
    check_val("drop_oneshot_done", obs_done - b_done, 0);

`ifdef COUNTER_NEST_DOWN_EN
    down = 1; oneshot = 1;
    cycle(1, 0, 0, 0);
    b_done = obs_done;
    cycle(0, 0, 0, 1);
    check_val("down_load", int'(cnt), int'({4'd2, 4'd1, 4'd3}));
    repeat (24) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check_val("down_done", obs_done - b_done, 1);
    down = 0;
`endif

    // Randomized mixed traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < LVL; i++) max[i*DW +: DW] = DW'($urandom_range(0, 3));
      end
`ifdef COUNTER_NEST_DOWN_EN
      if ($urandom_range(0, 29) == 0) down = ~down;
`endif
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
    end

    cycle(0, 0, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
